audio_mix_sched: RTL and testbench

Per-frame sample scheduler and mixer sitting in front of the I2S serializer. It accepts 16-bit signed samples from up to NUM_SRC independent producers, such as the speaker beep generator or PCM FIFOs, through valid/ready slots. On each frame request from the serializer it visits every source in a fixed sequence and sums their contributions with saturation. It then presents one mixed sample for the next frame.

---
 rtl/audio_mix_sched_if.sv | 30 +++
 rtl/audio_mix_sched.sv | 146 ++++++++++++++
 tb/tb_audio_mix_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/audio_mix_sched_if.sv
// Bundles the producer slots and the serializer handshake of audio_mix_sched.
// master = producers/serializer side, slave = the mixer.
interface audio_mix_sched_if #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 16
);
  logic                  frame_i;
  logic [NUM_SRC-1:0]    src_valid_i;
  logic [NUM_SRC*DW-1:0] src_data_i;
  logic [NUM_SRC-1:0]    src_mute_i;
  logic [NUM_SRC-1:0]    src_ready_o;
  logic [DW-1:0]         sample_o;
  logic                  sample_valid_o;
  logic                  busy_o;
  logic                  clip_o;
  logic                  overrun_o;
  logic [7:0]            underrun_cnt_o;

  modport master (
    output frame_i, src_valid_i, src_data_i, src_mute_i,
    input  src_ready_o, sample_o, sample_valid_o, busy_o, clip_o,
           overrun_o, underrun_cnt_o
  );

  modport slave (
    input  frame_i, src_valid_i, src_data_i, src_mute_i,
    output src_ready_o, sample_o, sample_valid_o, busy_o, clip_o,
           overrun_o, underrun_cnt_o
  );
endinterface

// File: rtl/audio_mix_sched.sv
// Per-frame scheduler/mixer: visits each source once per frame, saturating sum.
// Optional macro AUDIO_MIX_HOLD_TIMEOUT_EN silences sources stalled for HOLD_FRAMES frames.
module audio_mix_sched #(
  parameter int NUM_SRC     = 4,
  parameter int DW          = 16,
  parameter int HOLD_FRAMES = 65535
) (
  input logic              clk_i,
  input logic              rst_ni,
  audio_mix_sched_if.slave bus
);
  localparam int AW = DW + 3;
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic signed [AW-1:0] ACC_MAX = {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {4'b1111, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} state_t;

  state_t                r_state, w_state_next;
  logic [IW-1:0]         r_idx;
  logic signed [AW-1:0]  r_acc;
  logic [DW-1:0]         r_hold [NUM_SRC];
  logic [NUM_SRC-1:0]    r_fresh, r_taken;
  logic [DW-1:0]         r_sample;
  logic                  r_valid, r_clip, r_overrun;
  logic [7:0]            r_ucnt;

  logic [NUM_SRC-1:0]    w_ready, w_expired;
  logic                  w_last, w_under, w_hi, w_lo;
  logic [DW-1:0]         w_hold_sel, w_sat;
  logic signed [AW-1:0]  w_addend;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_ready
      assign w_ready[gi] = !r_fresh[gi] && (r_state == IDLE);
    end
  endgenerate

`ifdef AUDIO_MIX_HOLD_TIMEOUT_EN
  logic [15:0] r_cnt [NUM_SRC];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_SRC; k++) r_cnt[k] <= '0;
    end else if (r_state == OUT) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (r_taken[k])
          r_cnt[k] <= 16'(HOLD_FRAMES);
        else if (!bus.src_mute_i[k] && r_cnt[k] != 16'd0)
          r_cnt[k] <= r_cnt[k] - 16'd1;
      end
    end
  end

  // The underrun frame that takes the count from 1 to 0 is already silent, so a
  // single sample plays for at most HOLD_FRAMES frames in total.
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_exp
      assign w_expired[gi] = !r_taken[gi] && (r_cnt[gi] <= 16'd1);
    end
  endgenerate
`else
  assign w_expired = '0;
`endif

  assign w_last     = (r_idx == IW'(NUM_SRC - 1));
  assign w_hold_sel = r_hold[r_idx];
  assign w_addend   = AW'($signed(w_hold_sel));
  assign w_hi       = (r_acc > ACC_MAX);
  assign w_lo       = (r_acc < ACC_MIN);
  assign w_sat      = w_hi ? ACC_MAX[DW-1:0] : (w_lo ? ACC_MIN[DW-1:0] : r_acc[DW-1:0]);
  assign w_under    = |(~r_taken & ~bus.src_mute_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.frame_i) w_state_next = ACCUM;
      ACCUM:   if (w_last) w_state_next = SAT;
      SAT:     w_state_next = OUT;
      OUT:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx     <= '0;
      r_acc     <= '0;
      r_fresh   <= '0;
      r_taken   <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_clip    <= 1'b0;
      r_overrun <= 1'b0;
      r_ucnt    <= '0;
      for (int k = 0; k < NUM_SRC; k++) r_hold[k] <= '0;
    end else begin
      r_valid <= 1'b0;
      r_clip  <= 1'b0;
      if (bus.frame_i && r_state != IDLE) r_overrun <= 1'b1;

      // Slot loads only happen in IDLE; consumption only in OUT, so they never collide.
      for (int k = 0; k < NUM_SRC; k++) begin
        if (bus.src_valid_i[k] && w_ready[k]) begin
          r_hold[k]  <= bus.src_data_i[k*DW +: DW];
          r_fresh[k] <= 1'b1;
        end else if (r_state == OUT && r_taken[k]) begin
          r_fresh[k] <= 1'b0;
        end
      end

      case (r_state)
        IDLE: if (bus.frame_i) begin
          r_acc   <= '0;
          r_idx   <= '0;
          r_taken <= r_fresh;
        end
        ACCUM: begin
          if (!bus.src_mute_i[r_idx] && !w_expired[r_idx]) r_acc <= r_acc + w_addend;
          r_idx <= r_idx + 1'b1;
        end
        SAT: begin
          r_sample <= w_sat;
          r_clip   <= w_hi || w_lo;
          r_valid  <= 1'b1;
        end
        OUT: if (w_under && r_ucnt != 8'hFF) r_ucnt <= r_ucnt + 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.src_ready_o    = w_ready;
  assign bus.sample_o       = r_sample;
  assign bus.sample_valid_o = r_valid;
  assign bus.busy_o         = (r_state != IDLE);
  assign bus.clip_o         = r_clip;
  assign bus.overrun_o      = r_overrun;
  assign bus.underrun_cnt_o = r_ucnt;
endmodule

// File: tb/tb_audio_mix_sched.sv
// Directed bench for audio_mix_sched: vector table plus multi-cycle corner sequences.
module tb_audio_mix_sched;
  localparam int NS = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  audio_mix_sched_if #(.NUM_SRC(NS), .DW(DW)) bus ();

  audio_mix_sched #(.NUM_SRC(NS), .DW(DW), .HOLD_FRAMES(3)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  load;
    logic [63:0] data;
    logic [3:0]  mute;
    logic [15:0] exp_s;
    logic        exp_c;
    logic [7:0]  exp_u;
  } vec_t;

  vec_t tv [9];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] m, input logic [63:0] d);
    bus.src_valid_i = m;
    bus.src_data_i  = d;
    @(posedge clk); @(negedge clk);
    bus.src_valid_i = '0;
  endtask

  // Starts at a negedge in IDLE, returns at the negedge of the first IDLE cycle after OUT.
  task automatic run_frame(input logic [3:0] vm, input logic [63:0] vd,
                           output logic [15:0] s, output logic c);
    int n;
    bus.frame_i     = 1'b1;
    bus.src_valid_i = vm;
    bus.src_data_i  = vd;
    @(posedge clk); @(negedge clk);
    bus.frame_i     = 1'b0;
    bus.src_valid_i = '0;
    n = 1;
    chk("busy_in_mix", 32'(bus.busy_o), 32'd1);
    chk("ready_low_in_mix", 32'(bus.src_ready_o), 32'd0);
    while (!bus.sample_valid_o && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd6);
    s = bus.sample_o;
    c = bus.clip_o;
    @(posedge clk); @(negedge clk);
    chk("busy_after", 32'(bus.busy_o), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [15:0] s;
  logic        c;
  logic [15:0] exp_to [5];
  int          pulses;

  initial begin
    bus.frame_i     = 1'b0;
    bus.src_valid_i = '0;
    bus.src_data_i  = '0;
    bus.src_mute_i  = '0;

    //           load   data {s3,s2,s1,s0}                 mute   sample    clip  ucnt
    tv[0] = '{4'h0, 64'h0000_0000_0000_0000, 4'h0, 16'h0000, 1'b0, 8'd1};
    tv[1] = '{4'hF, 64'h0001_FF00_0200_0100, 4'h0, 16'h0201, 1'b0, 8'd1};
    tv[2] = '{4'h3, 64'h0000_0000_7000_7000, 4'hC, 16'h7FFF, 1'b1, 8'd1};
    tv[3] = '{4'h3, 64'h0000_0000_9000_9000, 4'hC, 16'h8000, 1'b1, 8'd1};
    tv[4] = '{4'hF, 64'h0000_FFFF_0010_1234, 4'h0, 16'h1243, 1'b0, 8'd1};
    tv[5] = '{4'h0, 64'h0000_0000_0000_0000, 4'h0, 16'h1243, 1'b0, 8'd2};
    tv[6] = '{4'h8, 64'h7FFF_0000_0000_0000, 4'h7, 16'h7FFF, 1'b0, 8'd2};
    tv[7] = '{4'h3, 64'h0000_0000_8000_8000, 4'hC, 16'h8000, 1'b1, 8'd2};
    tv[8] = '{4'h1, 64'h0000_0000_0000_8000, 4'hE, 16'h8000, 1'b0, 8'd2};

    do_reset();
    $display("reset: ready=%h sample=%h busy=%b", bus.src_ready_o, bus.sample_o, bus.busy_o);
    chk("rst_ready", 32'(bus.src_ready_o), 32'hF);
    chk("rst_sample", 32'(bus.sample_o), 32'h0);
    chk("rst_valid", 32'(bus.sample_valid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_clip", 32'(bus.clip_o), 32'd0);
    chk("rst_overrun", 32'(bus.overrun_o), 32'd0);
    chk("rst_ucnt", 32'(bus.underrun_cnt_o), 32'd0);

    for (int i = 0; i < 9; i++) begin
      bus.src_mute_i = tv[i].mute;
      if (tv[i].load != 4'h0) load(tv[i].load, tv[i].data);
      run_frame(4'h0, 64'h0, s, c);
      $display("vec %0d: sample=%h clip=%b ucnt=%0d ready=%h", i, s, c,
               bus.underrun_cnt_o, bus.src_ready_o);
      chk($sformatf("vec%0d_sample", i), 32'(s), 32'(tv[i].exp_s));
      chk($sformatf("vec%0d_clip", i), 32'(c), 32'(tv[i].exp_c));
      chk($sformatf("vec%0d_ucnt", i), 32'(bus.underrun_cnt_o), 32'(tv[i].exp_u));
      chk($sformatf("vec%0d_ready", i), 32'(bus.src_ready_o), 32'hF);
    end

    // Second frame request while mixing: ignored, sticky overrun, one output pulse.
    bus.src_mute_i = 4'h0;
    pulses = 0;
    bus.frame_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.frame_i = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.frame_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.frame_i = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (bus.sample_valid_o) pulses++;
      @(posedge clk); @(negedge clk);
    end
    $display("overrun: pulses=%0d overrun=%b busy=%b", pulses, bus.overrun_o, bus.busy_o);
    chk("ovr_pulses", 32'(pulses), 32'd1);
    chk("ovr_flag", 32'(bus.overrun_o), 32'd1);
    chk("ovr_idle", 32'(bus.busy_o), 32'd0);
    run_frame(4'h0, 64'h0, s, c);
    chk("ovr_sticky", 32'(bus.overrun_o), 32'd1);

    // Mute toggling on a source loaded once.
    do_reset();
    bus.src_mute_i = 4'hB;
    load(4'h4, 64'h0000_0400_0000_0000);
    for (int f = 0; f < 5; f++) begin
      bus.src_mute_i = (f % 2 == 1) ? 4'hF : 4'hB;
      run_frame(4'h0, 64'h0, s, c);
      $display("mute frame %0d: sample=%h ucnt=%0d", f, s, bus.underrun_cnt_o);
      chk($sformatf("mute%0d_sample", f), 32'(s), (f % 2 == 1) ? 32'h0 : 32'h0400);
      chk($sformatf("mute%0d_ucnt", f), 32'(bus.underrun_cnt_o), 32'(f / 2));
    end

    // Hold behaviour over five frames after a single load.
`ifdef AUDIO_MIX_HOLD_TIMEOUT_EN
    exp_to = '{16'h0400, 16'h0400, 16'h0400, 16'h0000, 16'h0000};
`else
    exp_to = '{16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400};
`endif
    do_reset();
    bus.src_mute_i = 4'hB;
    load(4'h4, 64'h0000_0400_0000_0000);
    for (int f = 0; f < 5; f++) begin
      run_frame(4'h0, 64'h0, s, c);
      $display("hold frame %0d: sample=%h", f, s);
      chk($sformatf("hold%0d_sample", f), 32'(s), 32'(exp_to[f]));
    end

    // Load coinciding with the frame request: slot stays fresh for the next frame.
    do_reset();
    bus.src_mute_i = 4'hB;
    run_frame(4'h4, 64'h0000_0400_0000_0000, s, c);
    $display("coincident frame: ucnt=%0d ready=%h", bus.underrun_cnt_o, bus.src_ready_o);
    chk("coin_ucnt", 32'(bus.underrun_cnt_o), 32'd1);
    chk("coin_ready", 32'(bus.src_ready_o), 32'hB);
    run_frame(4'h0, 64'h0, s, c);
    $display("coincident next: sample=%h ucnt=%0d ready=%h", s, bus.underrun_cnt_o, bus.src_ready_o);
    chk("coin_next_sample", 32'(s), 32'h0400);
    chk("coin_next_ucnt", 32'(bus.underrun_cnt_o), 32'd1);
    chk("coin_next_ready", 32'(bus.src_ready_o), 32'hF);

    // Reset during a mix aborts it without an output pulse.
    bus.src_mute_i = 4'h0;
    bus.frame_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.frame_i = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    chk("abort_valid", 32'(bus.sample_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.sample_valid_o) pulses++;
    end
    $display("abort: pulses=%0d ucnt=%0d", pulses, bus.underrun_cnt_o);
    chk("abort_pulses", 32'(pulses), 32'd0);
    chk("abort_ucnt", 32'(bus.underrun_cnt_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
